// File: rtl/fetch_queue_unit_pkg.sv
// Fetch front-end shared definitions: reset/exception vectors,
// fetch FSM encoding and FIFO entry sizing.
package fetch_queue_unit_pkg;

  localparam int unsigned ADDR_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_PC_DEF   = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF  = 32'h0000_3000;
  localparam int unsigned IM_BYTES_DEF = 16384;
  localparam int unsigned DEPTH_DEF    = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FAULT = 2'd1,
    ST_HALT  = 2'd2
  } fq_state_e;

  // Entry layout: {pc, instr[31:0], adel}
  function automatic int unsigned entry_w(
    input int unsigned aw
  );
    return aw + 33;
  endfunction

endpackage

// File: rtl/fetch_queue_unit_fifo.sv
// Synchronous fetch FIFO with flush-clear; head is
// presented combinationally from the read pointer.
module fetch_fifo
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned W     = entry_w(ADDR_W_DEF),
  parameter int unsigned DEPTH = DEPTH_DEF,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          push,
  input  logic [W-1:0]  data,
  input  logic          pop,
  input  logic          clear,
  output logic [CW-1:0] count,
  output logic [W-1:0]  head
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign head = mem[rd_ptr];

  a_no_overflow: assert property (
    @(posedge Clk) disable iff (!Rst_n)
    (push && !pop && !clear) |-> (count != CW'(DEPTH))
  );

  a_no_underflow: assert property (
    @(posedge Clk) disable iff (!Rst_n)
    (pop && !clear) |-> (count != '0)
  );

endmodule

// File: rtl/fetch_queue_unit.sv
// Instruction-fetch front end: PC, pipelined IM requests,
// in-order response buffering and decode handoff.
module fetch_queue_unit
  import fetch_queue_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter logic [ADDR_W-1:0] EXC_PC   = ADDR_W'(EXC_PC_DEF),
  parameter logic [ADDR_W-1:0] IM_BASE  = ADDR_W'(IM_BASE_DEF),
  parameter int unsigned IM_BYTES = IM_BYTES_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Redirect_i,
  input  logic [ADDR_W-1:0] Redirect_pc_i,
  input  logic              Exc_i,
  input  logic              Eret_i,
  input  logic [ADDR_W-1:0] Epc_i,
  output logic              Imem_req_valid_o,
  input  logic              Imem_req_ready_i,
  output logic [ADDR_W-1:0] Imem_req_addr_o,
  input  logic              Imem_rsp_valid_i,
  input  logic [31:0]       Imem_rsp_data_i,
  output logic              Dec_valid_o,
  input  logic              Dec_ready_i,
  output logic [ADDR_W-1:0] Dec_pc_o,
  output logic [31:0]       Dec_instr_o,
  output logic              Dec_adel_o,
  output logic [ADDR_W-1:0] Pc_o
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = entry_w(ADDR_W);
  localparam logic [ADDR_W:0] LO = {1'b0, IM_BASE};
  localparam logic [ADDR_W:0] HI = LO + (ADDR_W+1)'(IM_BYTES);

  fq_state_e         state;
  logic [ADDR_W-1:0] rsp_pc;
  logic [CW-1:0]     inflight;
  logic [CW-1:0]     discard;
  logic [CW-1:0]     count;
  logic [CW-1:0]     live;
  logic [CW:0]       occ;
  logic [ADDR_W-1:0] target;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head;
  logic              flush;
  logic              pc_bad;
  logic              credit_ok;
  logic              req_fire;
  logic              rsp_acc;
  logic              rsp_live;
  logic              fault_push;
  logic              push;
  logic              pop;

  function automatic logic bad_pc(
    input logic [ADDR_W-1:0] pc
  );
    logic [ADDR_W:0] wide;
    wide = {1'b0, pc};
    return (pc[1:0] != 2'b00) || (wide < LO) || (wide >= HI);
  endfunction

  assign flush = Exc_i | Eret_i | Redirect_i;

  always_comb begin
    target = Redirect_pc_i;
    unique case (1'b1)
      Exc_i:           target = EXC_PC;
      !Exc_i & Eret_i: target = Epc_i;
      default:         target = Redirect_pc_i;
    endcase
  end

  // Words still owed by IM that will be kept, plus words buffered
  assign live      = inflight - discard;
  assign occ       = {1'b0, live} + {1'b0, count};
  assign credit_ok = occ < (CW+1)'(DEPTH);
  assign pc_bad    = bad_pc(Pc_o);

  assign Imem_req_valid_o = Rst_n & (state == ST_RUN) & !flush
                          & !pc_bad & credit_ok;
  assign Imem_req_addr_o  = Pc_o;
  assign req_fire = Imem_req_valid_o & Imem_req_ready_i;

  assign rsp_acc  = Imem_rsp_valid_i & (inflight != '0);
  assign rsp_live = rsp_acc & (discard == '0) & !flush;

  // Fault entry waits until every kept response is in the queue
  assign fault_push = (state == ST_FAULT) & !flush
                    & (inflight == discard)
                    & (count < CW'(DEPTH));

  assign push = rsp_live | fault_push;

  always_comb begin
    push_data = {rsp_pc, Imem_rsp_data_i, 1'b0};
    if (fault_push) begin
      push_data = {Pc_o, 32'h0, 1'b1};
    end
  end

  assign Dec_valid_o = (count != '0) & !flush;
  assign pop         = Dec_valid_o & Dec_ready_i;
  assign Dec_pc_o    = head[EW-1 -: ADDR_W];
  assign Dec_instr_o = head[32:1];
  assign Dec_adel_o  = head[0];

  fetch_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .push  (push),
    .data  (push_data),
    .pop   (pop),
    .clear (flush),
    .count (count),
    .head  (head)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= ST_RUN;
      Pc_o     <= RESET_PC;
      rsp_pc   <= RESET_PC;
      inflight <= '0;
      discard  <= '0;
    end else if (flush) begin
      state    <= ST_RUN;
      Pc_o     <= target;
      rsp_pc   <= target;
      inflight <= inflight - CW'(rsp_acc);
      discard  <= inflight - CW'(rsp_acc);
    end else begin
      inflight <= inflight + CW'(req_fire) - CW'(rsp_acc);
      if (rsp_acc && (discard != '0)) begin
        discard <= discard - CW'(1);
      end
      if (rsp_live) begin
        rsp_pc <= rsp_pc + ADDR_W'(4);
      end
      if (req_fire) begin
        Pc_o <= Pc_o + ADDR_W'(4);
      end
      unique case (state)
        ST_RUN: begin
          if (pc_bad) begin
            state <= ST_FAULT;
          end
        end
        ST_FAULT: begin
          if (fault_push) begin
            state <= ST_HALT;
          end
        end
        ST_HALT: state <= ST_HALT;
        default: state <= ST_RUN;
      endcase
    end
  end

  a_rsp_expected: assert property (
    @(posedge Clk) disable iff (!Rst_n)
    Imem_rsp_valid_i |-> (inflight != '0)
  );

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit with a latency-
// programmable in-order instruction memory model.
module tb_fetch_queue_unit;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic        Redirect_i = 1'b0;
  logic [31:0] Redirect_pc_i = '0;
  logic        Exc_i = 1'b0;
  logic        Eret_i = 1'b0;
  logic [31:0] Epc_i = '0;
  logic        Imem_req_valid_o;
  logic        Imem_req_ready_i = 1'b1;
  logic [31:0] Imem_req_addr_o;
  logic        Imem_rsp_valid_i = 1'b0;
  logic [31:0] Imem_rsp_data_i = '0;
  logic        Dec_valid_o;
  logic        Dec_ready_i = 1'b0;
  logic [31:0] Dec_pc_o;
  logic [31:0] Dec_instr_o;
  logic        Dec_adel_o;
  logic [31:0] Pc_o;

  fetch_queue_unit dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Redirect_i       (Redirect_i),
    .Redirect_pc_i    (Redirect_pc_i),
    .Exc_i            (Exc_i),
    .Eret_i           (Eret_i),
    .Epc_i            (Epc_i),
    .Imem_req_valid_o (Imem_req_valid_o),
    .Imem_req_ready_i (Imem_req_ready_i),
    .Imem_req_addr_o  (Imem_req_addr_o),
    .Imem_rsp_valid_i (Imem_rsp_valid_i),
    .Imem_rsp_data_i  (Imem_rsp_data_i),
    .Dec_valid_o      (Dec_valid_o),
    .Dec_ready_i      (Dec_ready_i),
    .Dec_pc_o         (Dec_pc_o),
    .Dec_instr_o      (Dec_instr_o),
    .Dec_adel_o       (Dec_adel_o),
    .Pc_o             (Pc_o)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } exp_t;

  typedef struct {
    int          due;
    logic [31:0] addr;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] req_log[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat = 1;

  always @(posedge Clk) cyc <= cyc + 1;

  task automatic cmp(string nm, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  task automatic set_ready();
    Dec_ready_i = (exp_q.size() != 0);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic expect_e(logic [31:0] pc, logic [31:0] ins, logic adel);
    exp_t e;
    e.pc = pc;
    e.instr = ins;
    e.adel = adel;
    exp_q.push_back(e);
    set_ready();
  endtask

  task automatic wait_drain(string nm, int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain left=%0d want=0", nm, exp_q.size());
      exp_q.delete();
      set_ready();
    end
  endtask

  task automatic flush_cyc(string nm, logic exc, logic eret, logic redir,
                           logic [31:0] epc, logic [31:0] rpc);
    Exc_i = exc;
    Eret_i = eret;
    Redirect_i = redir;
    Epc_i = epc;
    Redirect_pc_i = rpc;
    #1;
    cmp({nm, "_flush_req"}, 32'(Imem_req_valid_o), 32'h0);
    cmp({nm, "_flush_dec"}, 32'(Dec_valid_o), 32'h0);
    tick();
    Exc_i = 1'b0;
    Eret_i = 1'b0;
    Redirect_i = 1'b0;
  endtask

  // Instruction memory: in-order, fixed latency, word = E000_0000 | addr
  initial begin
    logic        hs;
    logic [31:0] a;
    pend_t       p;
    forever begin
      @(negedge Clk);
      hs = Rst_n && Imem_req_valid_o && Imem_req_ready_i;
      a = Imem_req_addr_o;
      if (hs) begin
        p.due = cyc + lat;
        p.addr = a;
        pend_q.push_back(p);
        req_log.push_back(a);
      end
      @(posedge Clk);
      #1;
      Imem_rsp_valid_i = 1'b0;
      Imem_rsp_data_i = '0;
      if (!Rst_n) begin
        pend_q.delete();
      end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        Imem_rsp_valid_i = 1'b1;
        Imem_rsp_data_i = 32'hE000_0000 | pend_q[0].addr;
        void'(pend_q.pop_front());
      end
    end
  end

  // Monitor: every decode handshake is checked against the scoreboard
  initial begin
    forever begin
      @(negedge Clk);
      if (Rst_n && Dec_valid_o && Dec_ready_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL dec_unexpected got_pc=%h want=none", Dec_pc_o);
        end else begin
          cmp("dec_pc", Dec_pc_o, exp_q[0].pc);
          cmp("dec_instr", Dec_instr_o, exp_q[0].instr);
          cmp("dec_adel", 32'(Dec_adel_o), 32'(exp_q[0].adel));
          @(posedge Clk);
          #1;
          void'(exp_q.pop_front());
          set_ready();
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_ready();
    tick(2);
    cmp("rst_pc", Pc_o, 32'h3000);
    cmp("rst_req_valid", 32'(Imem_req_valid_o), 32'h0);
    cmp("rst_dec_valid", 32'(Dec_valid_o), 32'h0);
    cmp("rst_dec_pc", Dec_pc_o, 32'h0);
    cmp("rst_dec_instr", Dec_instr_o, 32'h0);
    cmp("rst_dec_adel", 32'(Dec_adel_o), 32'h0);
    Rst_n = 1'b1;

    // 1: streaming at one word per cycle
    expect_e(32'h3000, 32'hE000_3000, 1'b0);
    expect_e(32'h3004, 32'hE000_3004, 1'b0);
    expect_e(32'h3008, 32'hE000_3008, 1'b0);
    expect_e(32'h300C, 32'hE000_300C, 1'b0);
    wait_drain("t1", 8);
    cmp("t1_req0", req_log[0], 32'h3000);
    cmp("t1_req1", req_log[1], 32'h3004);
    cmp("t1_req3", req_log[3], 32'h300C);

    // 2: decode stalled, credit limit of four
    tick(4);
    req_log.delete();
    flush_cyc("t2", 1'b0, 1'b0, 1'b1, 32'h0, 32'h3000);
    tick(10);
    cmp("t2_req_cnt", 32'(req_log.size()), 32'd4);
    cmp("t2_req0", req_log[0], 32'h3000);
    cmp("t2_req3", req_log[3], 32'h300C);
    cmp("t2_stall_req", 32'(Imem_req_valid_o), 32'h0);
    cmp("t2_stall_pc", Pc_o, 32'h3010);
    expect_e(32'h3000, 32'hE000_3000, 1'b0);
    expect_e(32'h3004, 32'hE000_3004, 1'b0);
    expect_e(32'h3008, 32'hE000_3008, 1'b0);
    expect_e(32'h300C, 32'hE000_300C, 1'b0);
    expect_e(32'h3010, 32'hE000_3010, 1'b0);
    expect_e(32'h3014, 32'hE000_3014, 1'b0);
    wait_drain("t2", 30);

    // 3: redirect with two requests outstanding
    tick(6);
    lat = 3;
    flush_cyc("t3a", 1'b0, 1'b0, 1'b1, 32'h0, 32'h3000);
    tick(2);
    flush_cyc("t3b", 1'b0, 1'b0, 1'b1, 32'h0, 32'h3100);
    expect_e(32'h3100, 32'hE000_3100, 1'b0);
    expect_e(32'h3104, 32'hE000_3104, 1'b0);
    wait_drain("t3", 30);

    // 4: exception wins over ERET and redirect
    tick(2);
    flush_cyc("t4", 1'b1, 1'b1, 1'b1, 32'h3200, 32'h3100);
    cmp("t4_pc", Pc_o, 32'h4180);
    cmp("t4_dec_valid", 32'(Dec_valid_o), 32'h0);
    expect_e(32'h4180, 32'hE000_4180, 1'b0);
    wait_drain("t4", 30);

    // 5: misaligned target faults, ERET recovers
    tick(2);
    req_log.delete();
    flush_cyc("t5a", 1'b0, 1'b0, 1'b1, 32'h0, 32'h3102);
    expect_e(32'h3102, 32'h0, 1'b1);
    wait_drain("t5a", 40);
    tick(3);
    cmp("t5_halt_pc", Pc_o, 32'h3102);
    cmp("t5_halt_req", 32'(Imem_req_valid_o), 32'h0);
    cmp("t5_no_req", 32'(req_log.size()), 32'd0);
    flush_cyc("t5b", 1'b0, 1'b1, 1'b0, 32'h3008, 32'h0);
    expect_e(32'h3008, 32'hE000_3008, 1'b0);
    expect_e(32'h300C, 32'hE000_300C, 1'b0);
    wait_drain("t5b", 30);
    cmp("t5_resume_req", req_log[0], 32'h3008);

    // 6: asynchronous reset mid-cycle with requests outstanding
    tick(2);
    flush_cyc("t6", 1'b0, 1'b0, 1'b1, 32'h0, 32'h3000);
    tick(3);
    #2;
    Rst_n = 1'b0;
    Imem_rsp_valid_i = 1'b0;
    pend_q.delete();
    #1;
    cmp("t6_pc", Pc_o, 32'h3000);
    cmp("t6_req_valid", 32'(Imem_req_valid_o), 32'h0);
    cmp("t6_dec_valid", 32'(Dec_valid_o), 32'h0);
    cmp("t6_dec_pc", Dec_pc_o, 32'h0);
    cmp("t6_dec_instr", Dec_instr_o, 32'h0);
    tick(2);
    lat = 1;
    Rst_n = 1'b1;
    expect_e(32'h3000, 32'hE000_3000, 1'b0);
    expect_e(32'h3004, 32'hE000_3004, 1'b0);
    wait_drain("t6", 30);

    tick(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
